// File: rtl/stat_ram_rd_arbiter_if.sv
// Bundle of signals between the statistics-RAM read arbiter and its environment:
// two burst requesters, the RAM read port and the busy flag.
interface stat_ram_rd_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              i_enable;

    logic              i_req0;
    logic [ADDR_W-1:0] i_addr0;
    logic [ADDR_W:0]   i_len0;
    logic              o_gnt0;
    logic              o_rvalid0;
    logic              o_rlast0;
    logic [DATA_W-1:0] o_rdata0;
    logic              o_err0;

    logic              i_req1;
    logic [ADDR_W-1:0] i_addr1;
    logic [ADDR_W:0]   i_len1;
    logic              o_gnt1;
    logic              o_rvalid1;
    logic              o_rlast1;
    logic [DATA_W-1:0] o_rdata1;
    logic              o_err1;

    logic [ADDR_W-1:0] o_ram_raddr;
    logic              o_ram_ren;
    logic [DATA_W-1:0] i_ram_rdata;
    logic              o_busy;

    // Arbiter side
    modport slave (
        input  i_enable,
        input  i_req0, i_addr0, i_len0,
        output o_gnt0, o_rvalid0, o_rlast0, o_rdata0, o_err0,
        input  i_req1, i_addr1, i_len1,
        output o_gnt1, o_rvalid1, o_rlast1, o_rdata1, o_err1,
        output o_ram_raddr, o_ram_ren,
        input  i_ram_rdata,
        output o_busy
    );

    // Requesters / RAM side
    modport master (
        output i_enable,
        output i_req0, i_addr0, i_len0,
        input  o_gnt0, o_rvalid0, o_rlast0, o_rdata0, o_err0,
        output i_req1, i_addr1, i_len1,
        input  o_gnt1, o_rvalid1, o_rlast1, o_rdata1, o_err1,
        input  o_ram_raddr, o_ram_ren,
        output i_ram_rdata,
        input  o_busy
    );
endinterface

// File: rtl/stat_ram_rd_arbiter.sv
// Burst-level round-robin arbiter for the single read port of the cycle-statistics
// RAM. Requester 0 is the packet builder, requester 1 the health monitor.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no burst; arbitrate when enabled and a request is pending
// ISSUE  | one RAM address per cycle, wrapping modulo the RAM depth
// DRAIN  | addresses done; wait for the last beat, arbitrate on that beat
module stat_ram_rd_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input logic                 i_clk_50m,
    input logic                 i_rst,
    stat_ram_rd_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    state_t            state_q, state_d;

    // Requester that wins a tie; after a grant it points at the other one.
    logic              rr_prio_q, rr_prio_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              ren_q, ren_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              err0_q, err0_d;
    logic              err1_q, err1_d;

    // Return tag pipeline: valid / last / owner, aligned with the RAM latency.
    logic [RD_LAT-1:0] pv_q, pl_q, po_q;

    logic              rvalid0_q, rlast0_q;
    logic              rvalid1_q, rlast1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    logic              last_out;
    logic              arb_window;
    logic              do_grant;
    logic              winner;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W:0]   sel_len;
    logic              len_bad;
    logic              beat_v, beat_l, beat_o;

    assign last_out = rlast0_q | rlast1_q;
    assign beat_v   = pv_q[RD_LAT-1];
    assign beat_l   = pl_q[RD_LAT-1];
    assign beat_o   = po_q[RD_LAT-1];

    // Arbitration: IDLE, or the DRAIN cycle in which the final beat is output.
    always_comb begin
        arb_window = (state_q == S_IDLE) || ((state_q == S_DRAIN) && last_out);
        do_grant   = arb_window && bus.i_enable && (bus.i_req0 || bus.i_req1);
        if (bus.i_req0 && bus.i_req1) begin
            winner = rr_prio_q;
        end else begin
            winner = bus.i_req1;
        end
        sel_addr = winner ? bus.i_addr1 : bus.i_addr0;
        sel_len  = winner ? bus.i_len1  : bus.i_len0;
        len_bad  = (sel_len == '0) || (sel_len > MAX_LEN);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (do_grant && !len_bad) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_out) begin
                    state_d = (do_grant && !len_bad) ? S_ISSUE : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values: grants, address sequencing, beat counter
    always_comb begin
        rr_prio_d = rr_prio_q;
        owner_d   = owner_q;
        raddr_d   = raddr_q;
        cnt_d     = cnt_q;
        ren_d     = 1'b0;
        gnt0_d    = do_grant && !winner;
        gnt1_d    = do_grant && winner;
        err0_d    = do_grant && !winner && len_bad;
        err1_d    = do_grant && winner && len_bad;
        if (do_grant) begin
            rr_prio_d = ~winner;
            owner_d   = winner;
            if (!len_bad) begin
                raddr_d = sel_addr;
                cnt_d   = sel_len;
                ren_d   = 1'b1;
            end
        end else if ((state_q == S_ISSUE) && (cnt_q != CNT_ONE)) begin
            raddr_d = raddr_q + ADDR_W'(1);
            cnt_d   = cnt_q - CNT_ONE;
            ren_d   = 1'b1;
        end
    end

    // State and control registers
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            rr_prio_q <= 1'b0;
            owner_q   <= 1'b0;
            raddr_q   <= '0;
            ren_q     <= 1'b0;
            cnt_q     <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_prio_q <= rr_prio_d;
            owner_q   <= owner_d;
            raddr_q   <= raddr_d;
            ren_q     <= ren_d;
            cnt_q     <= cnt_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
        end
    end

    // Tag pipeline: each issued address carries valid/last/owner until its data arrives
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            pv_q <= '0;
            pl_q <= '0;
            po_q <= '0;
        end else begin
            pv_q[0] <= ren_q;
            pl_q[0] <= ren_q && (cnt_q == CNT_ONE);
            po_q[0] <= owner_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pl_q[i] <= pl_q[i-1];
                po_q[i] <= po_q[i-1];
            end
        end
    end

    // Return registers: RAM data steered to the owning requester only
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            rvalid0_q <= 1'b0;
            rlast0_q  <= 1'b0;
            rdata0_q  <= '0;
            rvalid1_q <= 1'b0;
            rlast1_q  <= 1'b0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= beat_v && !beat_o;
            rlast0_q  <= beat_v && beat_l && !beat_o;
            rvalid1_q <= beat_v && beat_o;
            rlast1_q  <= beat_v && beat_l && beat_o;
            if (beat_v && !beat_o) begin
                rdata0_q <= bus.i_ram_rdata;
            end
            if (beat_v && beat_o) begin
                rdata1_q <= bus.i_ram_rdata;
            end
        end
    end

    assign bus.o_gnt0      = gnt0_q;
    assign bus.o_err0      = err0_q;
    assign bus.o_rvalid0   = rvalid0_q;
    assign bus.o_rlast0    = rlast0_q;
    assign bus.o_rdata0    = rdata0_q;
    assign bus.o_gnt1      = gnt1_q;
    assign bus.o_err1      = err1_q;
    assign bus.o_rvalid1   = rvalid1_q;
    assign bus.o_rlast1    = rlast1_q;
    assign bus.o_rdata1    = rdata1_q;
    assign bus.o_ram_raddr = raddr_q;
    assign bus.o_ram_ren   = ren_q;
    assign bus.o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_stat_ram_rd_arbiter.sv
// Directed bench for stat_ram_rd_arbiter: one instance with RD_LAT=1 and one with
// RD_LAT=3, each in front of a RAM model returning addr*16.
module tb_stat_ram_rd_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #10 clk = ~clk;

    stat_ram_rd_arbiter_if #(.ADDR_W(6), .DATA_W(32)) bus1 ();
    stat_ram_rd_arbiter_if #(.ADDR_W(6), .DATA_W(32)) bus3 ();

    stat_ram_rd_arbiter #(.ADDR_W(6), .DATA_W(32), .RD_LAT(1)) dut1 (
        .i_clk_50m (clk),
        .i_rst     (rst),
        .bus       (bus1)
    );

    stat_ram_rd_arbiter #(.ADDR_W(6), .DATA_W(32), .RD_LAT(3)) dut3 (
        .i_clk_50m (clk),
        .i_rst     (rst),
        .bus       (bus3)
    );

    logic [31:0] rd3_a, rd3_b;

    // RAM models: 1-cycle and 3-cycle read latency, content = addr*16
    always @(posedge clk) begin
        bus1.i_ram_rdata <= 32'({bus1.o_ram_raddr, 4'h0});
        rd3_a            <= 32'({bus3.o_ram_raddr, 4'h0});
        rd3_b            <= rd3_a;
        bus3.i_ram_rdata <= rd3_b;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus1.i_enable = 1'b1; bus1.i_req0 = 1'b0; bus1.i_req1 = 1'b0;
        bus1.i_addr0 = '0; bus1.i_len0 = '0; bus1.i_addr1 = '0; bus1.i_len1 = '0;
        bus3.i_enable = 1'b1; bus3.i_req0 = 1'b0; bus3.i_req1 = 1'b0;
        bus3.i_addr0 = '0; bus3.i_len0 = '0; bus3.i_addr1 = '0; bus3.i_len1 = '0;
    endtask

    task automatic test_reset;
        logic [9:0] c1, c3;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        c1 = {bus1.o_gnt0, bus1.o_gnt1, bus1.o_rvalid0, bus1.o_rvalid1, bus1.o_rlast0,
              bus1.o_rlast1, bus1.o_err0, bus1.o_err1, bus1.o_busy, bus1.o_ram_ren};
        c3 = {bus3.o_gnt0, bus3.o_gnt1, bus3.o_rvalid0, bus3.o_rvalid1, bus3.o_rlast0,
              bus3.o_rlast1, bus3.o_err0, bus3.o_err1, bus3.o_busy, bus3.o_ram_ren};
        checks++; if (c1 !== 10'd0) begin errors++; $display("FAIL reset_ctrl1 got %b exp 0", c1); end
        checks++; if (c3 !== 10'd0) begin errors++; $display("FAIL reset_ctrl3 got %b exp 0", c3); end
        checks++; if ({bus1.o_rdata0, bus1.o_rdata1} !== 64'd0) begin errors++; $display("FAIL reset_rdata1 got %h %h exp 0", bus1.o_rdata0, bus1.o_rdata1); end
        checks++; if ({bus3.o_rdata0, bus3.o_rdata1} !== 64'd0) begin errors++; $display("FAIL reset_rdata3 got %h %h exp 0", bus3.o_rdata0, bus3.o_rdata1); end
        checks++; if (bus1.o_ram_raddr !== 6'd0) begin errors++; $display("FAIL reset_raddr1 got %0d exp 0", bus1.o_ram_raddr); end
        checks++; if (bus3.o_ram_raddr !== 6'd0) begin errors++; $display("FAIL reset_raddr3 got %0d exp 0", bus3.o_ram_raddr); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        logic [5:0]  e_gnt = 6'b000001;
        logic [5:0]  e_ren = 6'b000111;
        logic [5:0]  e_rv  = 6'b011100;
        logic [5:0]  e_rl  = 6'b010000;
        logic [5:0]  e_bsy = 6'b011111;
        logic [5:0]  e_adr [6] = '{6'd5, 6'd6, 6'd7, 6'd7, 6'd7, 6'd7};
        logic [31:0] e_dat [6] = '{32'h0, 32'h0, 32'h50, 32'h60, 32'h70, 32'h0};
        bus1.i_req0 = 1'b1; bus1.i_addr0 = 6'd5; bus1.i_len0 = 7'd3;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 0) bus1.i_req0 = 1'b0;
            checks++; if (bus1.o_gnt0 !== e_gnt[c]) begin errors++; $display("FAIL basic_gnt0 c%0d got %b exp %b", c, bus1.o_gnt0, e_gnt[c]); end
            checks++; if (bus1.o_ram_ren !== e_ren[c]) begin errors++; $display("FAIL basic_ren c%0d got %b exp %b", c, bus1.o_ram_ren, e_ren[c]); end
            checks++; if (bus1.o_ram_raddr !== e_adr[c]) begin errors++; $display("FAIL basic_raddr c%0d got %0d exp %0d", c, bus1.o_ram_raddr, e_adr[c]); end
            checks++; if (bus1.o_rvalid0 !== e_rv[c]) begin errors++; $display("FAIL basic_rvalid0 c%0d got %b exp %b", c, bus1.o_rvalid0, e_rv[c]); end
            checks++; if (bus1.o_rlast0 !== e_rl[c]) begin errors++; $display("FAIL basic_rlast0 c%0d got %b exp %b", c, bus1.o_rlast0, e_rl[c]); end
            checks++; if (bus1.o_busy !== e_bsy[c]) begin errors++; $display("FAIL basic_busy c%0d got %b exp %b", c, bus1.o_busy, e_bsy[c]); end
            checks++; if (bus1.o_rvalid1 !== 1'b0) begin errors++; $display("FAIL basic_rvalid1 c%0d got %b exp 0", c, bus1.o_rvalid1); end
            if (e_rv[c]) begin
                checks++; if (bus1.o_rdata0 !== e_dat[c]) begin errors++; $display("FAIL basic_rdata0 c%0d got %h exp %h", c, bus1.o_rdata0, e_dat[c]); end
            end
        end
    endtask

    task automatic test_wrap;
        logic [6:0]  e_ren = 7'b0001111;
        logic [6:0]  e_rv  = 7'b0111100;
        logic [6:0]  e_rl  = 7'b0100000;
        logic [6:0]  e_bsy = 7'b0111111;
        logic [5:0]  e_adr [7] = '{6'd62, 6'd63, 6'd0, 6'd1, 6'd1, 6'd1, 6'd1};
        logic [31:0] e_dat [7] = '{32'h0, 32'h0, 32'h3E0, 32'h3F0, 32'h0, 32'h10, 32'h0};
        bus1.i_req0 = 1'b1; bus1.i_addr0 = 6'd62; bus1.i_len0 = 7'd4;
        for (int c = 0; c < 7; c++) begin
            tick();
            if (c == 0) bus1.i_req0 = 1'b0;
            checks++; if (bus1.o_ram_ren !== e_ren[c]) begin errors++; $display("FAIL wrap_ren c%0d got %b exp %b", c, bus1.o_ram_ren, e_ren[c]); end
            checks++; if (bus1.o_ram_raddr !== e_adr[c]) begin errors++; $display("FAIL wrap_raddr c%0d got %0d exp %0d", c, bus1.o_ram_raddr, e_adr[c]); end
            checks++; if (bus1.o_rvalid0 !== e_rv[c]) begin errors++; $display("FAIL wrap_rvalid0 c%0d got %b exp %b", c, bus1.o_rvalid0, e_rv[c]); end
            checks++; if (bus1.o_rlast0 !== e_rl[c]) begin errors++; $display("FAIL wrap_rlast0 c%0d got %b exp %b", c, bus1.o_rlast0, e_rl[c]); end
            checks++; if (bus1.o_busy !== e_bsy[c]) begin errors++; $display("FAIL wrap_busy c%0d got %b exp %b", c, bus1.o_busy, e_bsy[c]); end
            if (e_rv[c]) begin
                checks++; if (bus1.o_rdata0 !== e_dat[c]) begin errors++; $display("FAIL wrap_rdata0 c%0d got %h exp %h", c, bus1.o_rdata0, e_dat[c]); end
            end
        end
    endtask

    task automatic test_round_robin;
        int          gnt_ord [$];
        int          gnt_cyc [$];
        int          last_cyc [$];
        logic [31:0] exp0 [4] = '{32'hA0, 32'hB0, 32'hA0, 32'hB0};
        logic [31:0] exp1 [4] = '{32'h140, 32'h150, 32'h140, 32'h150};
        int          n0 = 0;
        int          n1 = 0;
        bus1.i_req0 = 1'b1; bus1.i_addr0 = 6'd10; bus1.i_len0 = 7'd2;
        bus1.i_req1 = 1'b1; bus1.i_addr1 = 6'd20; bus1.i_len1 = 7'd2;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (bus1.o_gnt0 && bus1.o_gnt1) begin
                checks++; errors++; $display("FAIL rr_dual_gnt c%0d got 11 exp one-hot", c);
            end
            if (bus1.o_gnt0) begin gnt_ord.push_back(0); gnt_cyc.push_back(c); end
            if (bus1.o_gnt1) begin gnt_ord.push_back(1); gnt_cyc.push_back(c); end
            if (gnt_ord.size() >= 4) begin bus1.i_req0 = 1'b0; bus1.i_req1 = 1'b0; end
            if (bus1.o_rvalid0 || bus1.o_rvalid1) begin
                checks++; if (bus1.o_rvalid0 && bus1.o_rvalid1) begin errors++; $display("FAIL rr_cross_beat c%0d got both rvalid exp one", c); end
            end
            if (bus1.o_rvalid0 && n0 < 4) begin
                checks++; if (bus1.o_rdata0 !== exp0[n0]) begin errors++; $display("FAIL rr_rdata0 beat%0d got %h exp %h", n0, bus1.o_rdata0, exp0[n0]); end
                checks++; if (bus1.o_rlast0 !== n0[0]) begin errors++; $display("FAIL rr_rlast0 beat%0d got %b exp %b", n0, bus1.o_rlast0, n0[0]); end
                n0++;
            end
            if (bus1.o_rvalid1 && n1 < 4) begin
                checks++; if (bus1.o_rdata1 !== exp1[n1]) begin errors++; $display("FAIL rr_rdata1 beat%0d got %h exp %h", n1, bus1.o_rdata1, exp1[n1]); end
                checks++; if (bus1.o_rlast1 !== n1[0]) begin errors++; $display("FAIL rr_rlast1 beat%0d got %b exp %b", n1, bus1.o_rlast1, n1[0]); end
                n1++;
            end
            if ((bus1.o_rvalid0 && bus1.o_rlast0) || (bus1.o_rvalid1 && bus1.o_rlast1)) last_cyc.push_back(c);
        end
        bus1.i_req0 = 1'b0; bus1.i_req1 = 1'b0;
        checks++; if (gnt_ord.size() != 4) begin errors++; $display("FAIL rr_gnt_count got %0d exp 4", gnt_ord.size()); end
        checks++; if (n0 != 4 || n1 != 4) begin errors++; $display("FAIL rr_beat_count got %0d/%0d exp 4/4", n0, n1); end
        checks++; if (last_cyc.size() != 4) begin errors++; $display("FAIL rr_rlast_count got %0d exp 4", last_cyc.size()); end
        if (gnt_ord.size() == 4 && last_cyc.size() == 4) begin
            checks++; if (gnt_cyc[0] != 1) begin errors++; $display("FAIL rr_first_gnt_cycle got %0d exp 1", gnt_cyc[0]); end
            for (int i = 0; i < 4; i++) begin
                checks++; if (gnt_ord[i] != (i % 2)) begin errors++; $display("FAIL rr_order idx%0d got %0d exp %0d", i, gnt_ord[i], i % 2); end
            end
            for (int i = 1; i < 4; i++) begin
                checks++; if (gnt_cyc[i] != last_cyc[i-1] + 1) begin errors++; $display("FAIL rr_gap idx%0d got gnt %0d exp %0d", i, gnt_cyc[i], last_cyc[i-1] + 1); end
            end
        end
    endtask

    task automatic test_err;
        logic [6:0] bad [2] = '{7'd0, 7'd65};
        for (int k = 0; k < 2; k++) begin
            bus1.i_req1 = 1'b1; bus1.i_addr1 = 6'd3; bus1.i_len1 = bad[k];
            tick();
            bus1.i_req1 = 1'b0;
            checks++; if (bus1.o_gnt1 !== 1'b1) begin errors++; $display("FAIL err_gnt1 len%0d got %b exp 1", bad[k], bus1.o_gnt1); end
            checks++; if (bus1.o_err1 !== 1'b1) begin errors++; $display("FAIL err_err1 len%0d got %b exp 1", bad[k], bus1.o_err1); end
            checks++; if ({bus1.o_gnt0, bus1.o_err0, bus1.o_ram_ren, bus1.o_busy} !== 4'b0) begin errors++; $display("FAIL err_side len%0d got %b exp 0000", bad[k], {bus1.o_gnt0, bus1.o_err0, bus1.o_ram_ren, bus1.o_busy}); end
            for (int c = 1; c <= 4; c++) begin
                tick();
                checks++; if ({bus1.o_ram_ren, bus1.o_rvalid1, bus1.o_err1, bus1.o_gnt1} !== 4'b0) begin errors++; $display("FAIL err_after len%0d c%0d got %b exp 0000", bad[k], c, {bus1.o_ram_ren, bus1.o_rvalid1, bus1.o_err1, bus1.o_gnt1}); end
            end
        end
        bus1.i_req1 = 1'b1; bus1.i_addr1 = 6'd8; bus1.i_len1 = 7'd1;
        tick();
        bus1.i_req1 = 1'b0;
        checks++; if ({bus1.o_gnt1, bus1.o_err1, bus1.o_ram_ren} !== 3'b101) begin errors++; $display("FAIL err_legal_gnt got %b exp 101", {bus1.o_gnt1, bus1.o_err1, bus1.o_ram_ren}); end
        checks++; if (bus1.o_ram_raddr !== 6'd8) begin errors++; $display("FAIL err_legal_raddr got %0d exp 8", bus1.o_ram_raddr); end
        tick();
        tick();
        checks++; if ({bus1.o_rvalid1, bus1.o_rlast1} !== 2'b11) begin errors++; $display("FAIL err_legal_beat got %b exp 11", {bus1.o_rvalid1, bus1.o_rlast1}); end
        checks++; if (bus1.o_rdata1 !== 32'h80) begin errors++; $display("FAIL err_legal_rdata1 got %h exp 80", bus1.o_rdata1); end
        tick();
        checks++; if ({bus1.o_busy, bus1.o_rvalid1} !== 2'b00) begin errors++; $display("FAIL err_legal_end got %b exp 00", {bus1.o_busy, bus1.o_rvalid1}); end
    endtask

    task automatic test_enable;
        logic [31:0] e_dat [5] = '{32'h0, 32'h0, 32'h40, 32'h50, 32'h60};
        bus1.i_enable = 1'b0; bus1.i_req0 = 1'b1; bus1.i_addr0 = 6'd4; bus1.i_len0 = 7'd3;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++; if ({bus1.o_gnt0, bus1.o_busy} !== 2'b00) begin errors++; $display("FAIL en_blocked c%0d got %b exp 00", c, {bus1.o_gnt0, bus1.o_busy}); end
        end
        bus1.i_enable = 1'b1;
        tick();
        bus1.i_enable = 1'b0;
        checks++; if (bus1.o_gnt0 !== 1'b1) begin errors++; $display("FAIL en_gnt got %b exp 1", bus1.o_gnt0); end
        checks++; if (bus1.o_ram_raddr !== 6'd4) begin errors++; $display("FAIL en_raddr got %0d exp 4", bus1.o_ram_raddr); end
        for (int c = 1; c <= 8; c++) begin
            tick();
            checks++; if (bus1.o_gnt0 !== 1'b0) begin errors++; $display("FAIL en_no_regnt c%0d got %b exp 0", c, bus1.o_gnt0); end
            checks++; if (bus1.o_rvalid0 !== (c >= 2 && c <= 4)) begin errors++; $display("FAIL en_rvalid0 c%0d got %b", c, bus1.o_rvalid0); end
            checks++; if (bus1.o_rlast0 !== (c == 4)) begin errors++; $display("FAIL en_rlast0 c%0d got %b", c, bus1.o_rlast0); end
            if (c >= 2 && c <= 4) begin
                checks++; if (bus1.o_rdata0 !== e_dat[c]) begin errors++; $display("FAIL en_rdata0 c%0d got %h exp %h", c, bus1.o_rdata0, e_dat[c]); end
            end
        end
        bus1.i_enable = 1'b1;
        tick();
        bus1.i_req0 = 1'b0;
        checks++; if (bus1.o_gnt0 !== 1'b1) begin errors++; $display("FAIL en_regnt got %b exp 1", bus1.o_gnt0); end
        for (int c = 0; c < 6; c++) tick();
        checks++; if (bus1.o_busy !== 1'b0) begin errors++; $display("FAIL en_final_busy got %b exp 0", bus1.o_busy); end
    endtask

    task automatic test_reset_mid;
        bus1.i_req0 = 1'b1; bus1.i_addr0 = 6'd16; bus1.i_len0 = 7'd10;
        tick();
        bus1.i_req0 = 1'b0;
        checks++; if (bus1.o_gnt0 !== 1'b1) begin errors++; $display("FAIL rstmid_gnt got %b exp 1", bus1.o_gnt0); end
        tick(); tick(); tick();
        checks++; if (bus1.o_ram_raddr !== 6'd19) begin errors++; $display("FAIL rstmid_raddr got %0d exp 19", bus1.o_ram_raddr); end
        checks++; if ({bus1.o_rvalid0, bus1.o_rdata0} !== {1'b1, 32'h110}) begin errors++; $display("FAIL rstmid_beat got %b %h exp 1 110", bus1.o_rvalid0, bus1.o_rdata0); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({bus1.o_gnt0, bus1.o_gnt1, bus1.o_rvalid0, bus1.o_rvalid1, bus1.o_rlast0, bus1.o_rlast1,
                       bus1.o_err0, bus1.o_err1, bus1.o_busy, bus1.o_ram_ren} !== 10'd0) begin
            errors++; $display("FAIL rstmid_ctrl got nonzero exp 0");
        end
        checks++; if (bus1.o_rdata0 !== 32'h0) begin errors++; $display("FAIL rstmid_rdata0 got %h exp 0", bus1.o_rdata0); end
        checks++; if (bus1.o_ram_raddr !== 6'd0) begin errors++; $display("FAIL rstmid_raddr0 got %0d exp 0", bus1.o_ram_raddr); end
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++; if ({bus1.o_rvalid0, bus1.o_rvalid1, bus1.o_rlast0, bus1.o_rlast1, bus1.o_ram_ren, bus1.o_busy} !== 6'd0) begin
                errors++; $display("FAIL rstmid_quiet c%0d got %b exp 0", c, {bus1.o_rvalid0, bus1.o_rvalid1, bus1.o_rlast0, bus1.o_rlast1, bus1.o_ram_ren, bus1.o_busy});
            end
        end
        // Both requesting right after reset: a cleared pointer favours requester 0.
        bus1.i_req0 = 1'b1; bus1.i_addr0 = 6'd2;  bus1.i_len0 = 7'd1;
        bus1.i_req1 = 1'b1; bus1.i_addr1 = 6'd40; bus1.i_len1 = 7'd2;
        tick();
        bus1.i_req0 = 1'b0; bus1.i_req1 = 1'b0;
        checks++; if ({bus1.o_gnt0, bus1.o_gnt1} !== 2'b10) begin errors++; $display("FAIL rstmid_ptr got %b exp 10", {bus1.o_gnt0, bus1.o_gnt1}); end
        tick(); tick();
        checks++; if ({bus1.o_rvalid0, bus1.o_rlast0, bus1.o_rdata0} !== {2'b11, 32'h20}) begin errors++; $display("FAIL rstmid_b0 got %b%b %h exp 11 20", bus1.o_rvalid0, bus1.o_rlast0, bus1.o_rdata0); end
        tick();
        bus1.i_req1 = 1'b1;
        tick();
        bus1.i_req1 = 1'b0;
        checks++; if (bus1.o_gnt1 !== 1'b1) begin errors++; $display("FAIL rstmid_gnt1 got %b exp 1", bus1.o_gnt1); end
        tick(); tick();
        checks++; if ({bus1.o_rvalid1, bus1.o_rlast1, bus1.o_rdata1} !== {2'b10, 32'h280}) begin errors++; $display("FAIL rstmid_r1a got %b%b %h exp 10 280", bus1.o_rvalid1, bus1.o_rlast1, bus1.o_rdata1); end
        tick();
        checks++; if ({bus1.o_rvalid1, bus1.o_rlast1, bus1.o_rdata1} !== {2'b11, 32'h290}) begin errors++; $display("FAIL rstmid_r1b got %b%b %h exp 11 290", bus1.o_rvalid1, bus1.o_rlast1, bus1.o_rdata1); end
        checks++; if (bus1.o_rvalid0 !== 1'b0) begin errors++; $display("FAIL rstmid_r0_quiet got %b exp 0", bus1.o_rvalid0); end
        tick();
        checks++; if (bus1.o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_end_busy got %b exp 0", bus1.o_busy); end
    endtask

    task automatic test_rdlat3;
        logic [7:0]  e_ren = 8'b00000111;
        logic [7:0]  e_rv  = 8'b01110000;
        logic [7:0]  e_rl  = 8'b01000000;
        logic [7:0]  e_bsy = 8'b01111111;
        logic [31:0] e_dat [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h50, 32'h60, 32'h70, 32'h0};
        bus3.i_req0 = 1'b1; bus3.i_addr0 = 6'd5; bus3.i_len0 = 7'd3;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (c == 0) bus3.i_req0 = 1'b0;
            checks++; if (bus3.o_gnt0 !== (c == 0)) begin errors++; $display("FAIL lat3_gnt0 c%0d got %b", c, bus3.o_gnt0); end
            checks++; if (bus3.o_ram_ren !== e_ren[c]) begin errors++; $display("FAIL lat3_ren c%0d got %b exp %b", c, bus3.o_ram_ren, e_ren[c]); end
            checks++; if (bus3.o_rvalid0 !== e_rv[c]) begin errors++; $display("FAIL lat3_rvalid0 c%0d got %b exp %b", c, bus3.o_rvalid0, e_rv[c]); end
            checks++; if (bus3.o_rlast0 !== e_rl[c]) begin errors++; $display("FAIL lat3_rlast0 c%0d got %b exp %b", c, bus3.o_rlast0, e_rl[c]); end
            checks++; if (bus3.o_busy !== e_bsy[c]) begin errors++; $display("FAIL lat3_busy c%0d got %b exp %b", c, bus3.o_busy, e_bsy[c]); end
            if (e_rv[c]) begin
                checks++; if (bus3.o_rdata0 !== e_dat[c]) begin errors++; $display("FAIL lat3_rdata0 c%0d got %h exp %h", c, bus3.o_rdata0, e_dat[c]); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_round_robin();
        test_basic();
        test_wrap();
        test_err();
        test_enable();
        test_reset_mid();
        test_rdlat3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
